// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one carry-chain slice of WIDTH/STAGES bits per stage.
// Latency: STAGES cycles from the accepting edge to out_valid, when there are no stalls.
// Backpressure: the whole pipe freezes when out_valid=1 and out_ready=0; in_ready is low while frozen or in reset.
module pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;

  // Per-stage registers. Operands travel at full width so that every stage
  // picks its own slice with a fixed offset. b_q holds B' (already inverted
  // for subtract), so the last stage sees the effective operand sign.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  // Stage inputs (from the ports for stage 0, from the previous register otherwise).
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] s_i [STAGES];
  logic             c_i [STAGES];
  logic             v_i [STAGES];

  // Next-state values produced by each stage's slice adder.
  logic [WIDTH-1:0] s_n [STAGES];
  logic             c_n [STAGES];
  logic [SW:0]      slice;

  logic advance;

  assign advance   = out_ready | ~v_q[STAGES-1];
  assign in_ready  = advance & ~reset;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  // Flags are gated with out_valid so they read 0 after reset; they derive
  // only from held registers, so they stay stable across a stall.
  assign ovf  = v_q[STAGES-1]
              & (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
              & (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  assign zero = v_q[STAGES-1] & ~(|s_q[STAGES-1]);

  // Only the sign bits of the operands are consumed after the last slice.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1][WIDTH-2:0], b_q[STAGES-1][WIDTH-2:0]};

  // Route stage inputs: stage 0 takes the ports (subtract = add ~b with carry-in 1).
  always_comb begin
    a_i[0] = a;
    b_i[0] = sub ? ~b : b;
    c_i[0] = sub | cin;
    s_i[0] = '0;
    v_i[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      s_i[k] = s_q[k-1];
      v_i[k] = v_q[k-1];
    end
  end

  // Each stage adds its own slice and merges it into the partial result.
  always_comb begin
    slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice = {1'b0, a_i[k][k*SW +: SW]}
            + {1'b0, b_i[k][k*SW +: SW]}
            + {{SW{1'b0}}, c_i[k]};
      s_n[k] = s_i[k];
      s_n[k][k*SW +: SW] = slice[SW-1:0];
      c_n[k] = slice[SW];
    end
  end

  // Pipeline registers: cleared on reset, shift together on advance, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_n[k];
        c_q[k] <= c_n[k];
        v_q[k] <= v_i[k];
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three instances (STAGES = 1, 4, 8) share one stimulus stream.
// Each instance has its own scoreboard, filled from an arithmetic reference model at acceptance.
// Only the STAGES=4 instance sees downstream stalls; the others always have out_ready=1.
module tb_pipe_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [31:0] t;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] a, b;
  logic        cin, sub;
  logic        rdy4;

  logic        i_rdy [3];
  logic        o_vld [3];
  logic        o_rdy [3];
  logic [63:0] o_sum [3];
  logic        o_cout [3];
  logic        o_ovf [3];
  logic        o_zero [3];

  exp_t        sb [3][$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          stall_mode = 0;
  int          pat = 0;
  bit          lat_chk = 1'b0;

  function automatic int st_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 8;
  endfunction

  assign o_rdy[0] = 1'b1;
  assign o_rdy[1] = rdy4;
  assign o_rdy[2] = 1'b1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    pipe_adder #(.WIDTH(64), .STAGES(st_of(gi))) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (i_rdy[gi]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (o_vld[gi]),
      .out_ready (o_rdy[gi]),
      .sum       (o_sum[gi]),
      .cout      (o_cout[gi]),
      .ovf       (o_ovf[gi]),
      .zero      (o_zero[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness for the STAGES=4 instance: always, 1,0,0 pattern, or random.
  always @(posedge clk) begin
    #1;
    pat = (pat + 1) % 3;
    case (stall_mode)
      0:       rdy4 = 1'b1;
      1:       rdy4 = (pat == 0);
      default: rdy4 = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact unsigned and signed arithmetic, then derive the flags.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input logic sb_, input logic [31:0] t);
    exp_t r;
    logic [64:0] full;
    logic signed [65:0] sx, sy, sres, strunc;
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    if (sb_) begin
      full   = {1'b0, x} - {1'b0, y};
      r.cout = (x >= y);
      sres   = sx - sy;
    end else begin
      full   = {1'b0, x} + {1'b0, y} + {64'd0, ci};
      r.cout = full[64];
      sres   = sx + sy + $signed({65'd0, ci});
    end
    r.sum  = full[63:0];
    strunc = $signed({{2{full[63]}}, full[63:0]});
    r.ovf  = (sres != strunc);
    r.zero = (r.sum == 64'd0);
    r.t    = t;
    return r;
  endfunction

  // Scoreboard push on acceptance, check/pop on emission, checked mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (o_vld[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("stale_out_s%0d", st_of(i)), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb[i][0];
            chk($sformatf("sum_s%0d", st_of(i)), o_sum[i], e.sum);
            chk($sformatf("cout_s%0d", st_of(i)), 64'(o_cout[i]), 64'(e.cout));
            chk($sformatf("ovf_s%0d", st_of(i)), 64'(o_ovf[i]), 64'(e.ovf));
            chk($sformatf("zero_s%0d", st_of(i)), 64'(o_zero[i]), 64'(e.zero));
            if (o_rdy[i]) begin
              if (lat_chk)
                chk($sformatf("latency_s%0d", st_of(i)), 64'(cyc - int'(e.t)), 64'(st_of(i)));
              void'(sb[i].pop_front());
            end else begin
              chk($sformatf("in_ready_stall_s%0d", st_of(i)), 64'(i_rdy[i]), 64'd0);
            end
          end
        end
        if (in_valid && i_rdy[i])
          sb[i].push_back(model(a, b, cin, sub, 32'(cyc)));
      end
    end
  end

  // Offer one beat and hold it until the STAGES=4 instance takes it.
  task automatic put(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb_);
    bit ok;
    a = x; b = y; cin = ci; sub = sb_; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (i_rdy[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("drain_s%0d", st_of(i)), 64'(sb[i].size()), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'(32'($urandom_range(0, 15)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; rdy4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready_s%0d", st_of(i)), 64'(i_rdy[i]), 64'd0);
      chk($sformatf("rst_out_valid_s%0d", st_of(i)), 64'(o_vld[i]), 64'd0);
      chk($sformatf("rst_sum_s%0d", st_of(i)), o_sum[i], 64'd0);
      chk($sformatf("rst_flags_s%0d", st_of(i)), 64'({o_cout[i], o_ovf[i], o_zero[i]}), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Directed vectors, one isolated beat each, latency checked.
    lat_chk = 1'b1;
    put(64'd0, 64'd4, 1'b0, 1'b0);                                   drain();
    put(-64'sd2, -64'sd1, 1'b0, 1'b0);                               drain();
    put(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);                 drain();
    put(64'd1000, 64'd1000, 1'b0, 1'b1);                             drain();
    put(64'd0, 64'd1, 1'b0, 1'b1);                                   drain();
    put(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);                 drain();
    put(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);                 drain();
    lat_chk = 1'b0;

    // 16 back-to-back beats with the 1,0,0 downstream pattern.
    stall_mode = 1;
    for (int n = 0; n < 16; n++) put(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Random traffic with random gaps and random downstream stalls.
    stall_mode = 2;
    for (int n = 0; n < 200; n++) begin
      put(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Reset with three beats in flight: nothing may emerge afterwards.
    stall_mode = 0;
    idle(1);
    put(64'd11, 64'd22, 1'b0, 1'b0);
    put(64'd33, 64'd44, 1'b0, 1'b0);
    put(64'd55, 64'd66, 1'b0, 1'b0);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_out_valid_s%0d", st_of(i)), 64'(o_vld[i]), 64'd0);
      chk($sformatf("midrst_sum_s%0d", st_of(i)), o_sum[i], 64'd0);
    end
    @(posedge clk); #1;
    idle(12);
    lat_chk = 1'b1;
    put(64'd5, 64'd7, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
